// File: rtl/trng_ctrl_if.sv
// Bundle of the TRNG controller's session control, LFSR pins and the
// random-word valid/ready port. The controller sits on the slave side.
interface trng_ctrl_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] seed_cfg;
    logic             lfsr_en;
    logic             lfsr_seed_we;
    logic [WIDTH-1:0] lfsr_seed;
    logic [WIDTH-1:0] lfsr_data;
    logic [WIDTH-1:0] rnd_data;
    logic             rnd_valid;
    logic             rnd_ready;
    logic             busy;
    logic             error;

    modport slave (
        input  start, stop, seed_cfg, lfsr_data, rnd_ready,
        output lfsr_en, lfsr_seed_we, lfsr_seed, rnd_data, rnd_valid, busy, error
    );

    modport master (
        output start, stop, seed_cfg, lfsr_data, rnd_ready,
        input  lfsr_en, lfsr_seed_we, lfsr_seed, rnd_data, rnd_valid, busy, error
    );
endinterface

// File: rtl/trng_ctrl.sv
// TRNG LFSR sequencer: seed, warm-up, decimation bursts, word capture with
// valid/ready output, and a repetition-count health test with a sticky fault.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start
// SEED    | one cycle of lfsr_seed_we, health-test history cleared
// WARMUP  | LFSR shifts WARMUP cycles, no words produced
// SHIFT   | LFSR shifts DECIM cycles per word
// CAPTURE | LFSR paused, word sampled and health-tested
// VALID   | word presented, LFSR paused until the handshake
// FAULT   | repetition limit hit; terminal until rst
module trng_ctrl #(
    parameter int WIDTH     = 10,
    parameter int WARMUP    = 64,
    parameter int DECIM     = 10,
    parameter int REP_LIMIT = 4
) (
    input logic         clk,
    input logic         rst,
    trng_ctrl_if.slave  bus
);
    localparam int CNT_MAX = (WARMUP > DECIM) ? WARMUP : DECIM;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(REP_LIMIT + 1);
    localparam logic [CW-1:0] WARM_LAST  = CW'(WARMUP - 1);
    localparam logic [CW-1:0] DECIM_LAST = CW'(DECIM - 1);
    localparam logic [RW-1:0] REP_MAX    = RW'(REP_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_WARMUP, S_SHIFT, S_CAPTURE, S_VALID, S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
    logic [RW-1:0]    rep_q, rep_d;
    logic             lfsr_en_q, lfsr_en_d;
    logic             seed_we_q, seed_we_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             error_q, error_d;
    logic [RW-1:0]    rep_new;
    logic             in_session;

    assign rep_new    = (prev_valid_q && (bus.lfsr_data == prev_q)) ? rep_q + RW'(1) : RW'(1);
    assign in_session = (state_q != S_IDLE) && (state_q != S_FAULT);

    // Next-state, datapath updates and Moore output decode of the next state
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        seed_d       = seed_q;
        data_d       = data_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        rep_d        = rep_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = S_SEED;
                    seed_d  = bus.seed_cfg;
                end
            end
            S_SEED: begin
                rep_d        = '0;
                prev_valid_d = 1'b0;
                cnt_d        = '0;
                state_d      = S_WARMUP;
            end
            S_WARMUP: begin
                if (cnt_q == WARM_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SHIFT: begin
                if (cnt_q == DECIM_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CAPTURE: begin
                data_d       = bus.lfsr_data;
                prev_d       = bus.lfsr_data;
                prev_valid_d = 1'b1;
                rep_d        = rep_new;
                // A faulting word is never presented
                state_d      = (rep_new == REP_MAX) ? S_FAULT : S_VALID;
            end
            S_VALID: begin
                if (bus.rnd_ready) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
        // stop overrides every in-session transition and drops any pending word
        if (bus.stop && in_session) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
        seed_we_d = (state_d == S_SEED);
        lfsr_en_d = (state_d == S_WARMUP) || (state_d == S_SHIFT);
        valid_d   = (state_d == S_VALID);
        error_d   = (state_d == S_FAULT);
        busy_d    = (state_d != S_IDLE) && (state_d != S_FAULT);
    end

    // State, datapath and registered output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            seed_q       <= '0;
            data_q       <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            rep_q        <= '0;
            lfsr_en_q    <= 1'b0;
            seed_we_q    <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            seed_q       <= seed_d;
            data_q       <= data_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            rep_q        <= rep_d;
            lfsr_en_q    <= lfsr_en_d;
            seed_we_q    <= seed_we_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
        end
    end

    assign bus.lfsr_en      = lfsr_en_q;
    assign bus.lfsr_seed_we = seed_we_q;
    assign bus.lfsr_seed    = seed_q;
    assign bus.rnd_data     = data_q;
    assign bus.rnd_valid    = valid_q;
    assign bus.busy         = busy_q;
    assign bus.error        = error_q;
endmodule

// File: tb/tb_trng_ctrl.sv
// Bench for trng_ctrl: a behavioural LFSR plant feeds the controller, a
// reference model predicts each word as the seed advanced WARMUP+n*DECIM
// steps, and a monitor compares every newly presented word against a queue.
module tb_trng_ctrl;
    localparam int WIDTH     = 10;
    localparam int WARMUP    = 4;
    localparam int DECIM     = 10;
    localparam int REP_LIMIT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trng_ctrl_if #(.WIDTH(WIDTH)) bus ();

    trng_ctrl #(
        .WIDTH(WIDTH), .WARMUP(WARMUP), .DECIM(DECIM), .REP_LIMIT(REP_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;
    logic             const_mode = 1'b0;
    logic [WIDTH-1:0] sess_seed  = '0;
    logic [WIDTH-1:0] sb[$];

    // x^10 + x^7 + 1 maximal-length LFSR
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
        return {x[8:0], x[9] ^ x[6]};
    endfunction

    function automatic logic [WIDTH-1:0] exp_word(input int n);
        logic [WIDTH-1:0] x;
        if (const_mode) return 10'h155;
        x = sess_seed;
        for (int i = 0; i < WARMUP + n * DECIM; i++) x = lfsr_next(x);
        return x;
    endfunction

    // LFSR plant
    logic [WIDTH-1:0] plant_q = '0;
    always @(posedge clk) begin
        if (bus.lfsr_seed_we) plant_q <= bus.lfsr_seed;
        else if (bus.lfsr_en) plant_q <= lfsr_next(plant_q);
    end
    assign bus.lfsr_data = const_mode ? 10'h155 : plant_q;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    function automatic int all_outs();
        return int'({bus.lfsr_en, bus.lfsr_seed_we, bus.lfsr_seed, bus.rnd_data,
                     bus.rnd_valid, bus.busy, bus.error});
    endfunction

    // Monitor: pops the scoreboard whenever a new word appears, checks stability while stalled
    logic             mon_pv = 1'b0;
    logic             mon_pr = 1'b0;
    logic [WIDTH-1:0] mon_pd = '0;
    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        #1;
        if (rst) begin
            mon_pv = 1'b0;
        end else begin
            if (bus.rnd_valid) begin
                if (mon_pv && !mon_pr) begin
                    chk("data_stable", int'(bus.rnd_data), int'(mon_pd));
                end else if (sb.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("word_value", int'(bus.rnd_data), int'(e));
                end
            end
            mon_pv = bus.rnd_valid;
            mon_pr = bus.rnd_ready;
            mon_pd = bus.rnd_data;
        end
    end

    task automatic start_session(input logic [WIDTH-1:0] s);
        sess_seed    = s;
        bus.seed_cfg = s;
        bus.start    = 1'b1;
        t0           = cyc;
        sb.push_back(exp_word(1));
        tick();
        bus.start    = 1'b0;
        bus.seed_cfg = $urandom_range(0, 1023);
        chk("seed_we_c1", bus.lfsr_seed_we, 1);
        chk("seed_val_c1", int'(bus.lfsr_seed), int'(s));
    endtask

    task automatic wait_valid(input int exp_cyc);
        int lim = 0;
        while (!bus.rnd_valid && lim < 200) begin
            tick();
            lim++;
        end
        chk("first_valid_cycle", cyc, exp_cyc);
    endtask

    task automatic handshake(input int n, input int stall);
        int k;
        int ens = 0;
        int lim = 0;
        if (stall > 0) begin
            bus.rnd_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                chk("stall_valid", bus.rnd_valid, 1);
                chk("stall_en", bus.lfsr_en, 0);
                tick();
            end
        end
        bus.rnd_ready = 1'b1;
        k = cyc;
        sb.push_back(exp_word(n + 1));
        tick();
        while (!bus.rnd_valid && lim < 60) begin
            ens += int'(bus.lfsr_en);
            tick();
            lim++;
        end
        chk("next_valid_cycle", cyc, k + DECIM + 2);
        chk("en_per_word", ens, DECIM);
    endtask

    task automatic do_stop();
        bus.stop      = 1'b1;
        bus.rnd_ready = 1'b0;
        tick();
        bus.stop = 1'b0;
        chk("stop_idle", int'({bus.busy, bus.rnd_valid, bus.lfsr_en, bus.lfsr_seed_we}), 0);
        sb.delete();
    endtask

    task automatic rand_seed(output logic [WIDTH-1:0] s);
        s = WIDTH'($urandom_range(1, 1023));
    endtask

    initial begin
        logic [WIDTH-1:0] s;
        int k;
        bus.start = 1'b0; bus.stop = 1'b0; bus.seed_cfg = '0; bus.rnd_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", all_outs(), 0);

        // Directed session: seed 0x2A5, cycle-accurate startup
        start_session(10'h2A5);
        for (int c = 1; c <= 3 + WARMUP + DECIM; c++) begin
            chk("seed_we_window", bus.lfsr_seed_we, int'(c == 1));
            chk("en_window", bus.lfsr_en, int'(c >= 2 && c <= 1 + WARMUP + DECIM));
            chk("valid_window", bus.rnd_valid, int'(c == 3 + WARMUP + DECIM));
            if (c < 3 + WARMUP + DECIM) tick();
        end
        handshake(1, 7);
        for (int n = 2; n <= 6; n++) handshake(n, 0);
        do_stop();

        // Reseed after stop, then stop in SHIFT
        rand_seed(s);
        start_session(s);
        while (cyc < t0 + 2 + WARMUP + 3) tick();
        chk("shift_en", bus.lfsr_en, 1);
        chk("shift_busy", bus.busy, 1);
        do_stop();
        rand_seed(s);
        start_session(s);
        wait_valid(t0 + 3 + WARMUP + DECIM);
        do_stop();

        // Randomised sessions with random backpressure
        for (int r = 0; r < 3; r++) begin
            rand_seed(s);
            start_session(s);
            wait_valid(t0 + 3 + WARMUP + DECIM);
            for (int n = 1; n < int'($urandom_range(3, 6)); n++) handshake(n, $urandom_range(0, 6));
            do_stop();
        end

        // start and stop together in IDLE
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("start_stop_idle", int'({bus.busy, bus.lfsr_seed_we, bus.lfsr_en}), 0);
            tick();
        end

        // rst during WARMUP
        rand_seed(s);
        start_session(s);
        tick(); tick();
        chk("in_warmup", bus.lfsr_en, 1);
        rst = 1'b1;
        tick();
        chk("rst_mid_session", all_outs(), 0);
        rst = 1'b0;
        sb.delete();
        tick();

        // Health test with a stuck LFSR
        const_mode = 1'b1;
        rand_seed(s);
        start_session(s);
        wait_valid(t0 + 3 + WARMUP + DECIM);
        handshake(1, 0);
        k = cyc;
        tick();
        for (int c = 1; c <= DECIM + 2; c++) begin
            chk("fault_no_valid", bus.rnd_valid, 0);
            chk("fault_error_rise", bus.error, int'(c == DECIM + 2));
            if (c < DECIM + 2) tick();
        end
        chk("fault_busy", bus.busy, 0);
        chk("fault_en", bus.lfsr_en, 0);
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fault_ignore_start", int'({bus.error, bus.busy, bus.lfsr_seed_we}), 4);
        end
        bus.start = 1'b0; bus.stop = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("fault_ignore_stop", int'({bus.error, bus.busy}), 2);
        end
        bus.stop = 1'b0;
        rst = 1'b1;
        tick();
        chk("fault_cleared", bus.error, 0);
        chk("fault_rst_outputs", all_outs(), 0);
        rst = 1'b0;
        const_mode = 1'b0;
        sb.delete();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/trng_ctrl.md
# trng_ctrl

Sequencing controller for the TRNG LFSR. It seeds the LFSR, runs a warm-up period and then clocks the LFSR in decimation bursts. After each burst it captures one random word and presents it on a valid/ready output port. A repetition-count health test latches a sticky fault when the captured word stream stops changing. The block sits between the LFSR instance (via its en/seed_we/seed/data_out pins) and the TRNG consumer.

## Interface
Parameters:
- WIDTH, 10: LFSR and output word width.
- WARMUP, 64: LFSR shift cycles after seeding before the first word is generated; must be ≥1.
- DECIM, 10: LFSR shift cycles per output word; must be ≥1.
- REP_LIMIT, 4: number of consecutive identical captured words that raises a fault; must be ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level sampled each cycle; begins a generation session from IDLE.
- stop  in  1  level sampled each cycle; aborts the session and returns the block to IDLE.
- seed_cfg  in  WIDTH  seed value, captured into a register in the cycle start is accepted.
- lfsr_en  out  1  drives LFSR en.
- lfsr_seed_we  out  1  drives LFSR seed_we.
- lfsr_seed  out  WIDTH  drives LFSR seed; equals the captured seed register.
- lfsr_data  in  WIDTH  LFSR data_out.
- rnd_data  out  WIDTH  captured random word.
- rnd_valid  out  1  rnd_data is valid.
- rnd_ready  in  1  consumer accepts the word.
- busy  out  1  high in SEED, WARMUP, SHIFT, CAPTURE and VALID.
- error  out  1  sticky health-test fault.

## Operation
- States: IDLE, SEED, WARMUP, SHIFT, CAPTURE, VALID, FAULT. One state register and one cycle counter, with width clog2(max(WARMUP,DECIM)+1).
- All control outputs are Moore-decoded from the state register only:
  - lfsr_seed_we=1 only in SEED.
  - lfsr_en=1 only in WARMUP and SHIFT.
  - rnd_valid=1 only in VALID.
  - error=1 only in FAULT.
- IDLE:
  - start=1 and stop=0 → SEED; seed register ← seed_cfg.
  - If start and stop are both high, stop wins and the block stays in IDLE.
- SEED: lasts 1 cycle. Clears the repetition counter and the prev_valid flag, then → WARMUP with counter=0.
- WARMUP: lasts exactly WARMUP cycles, then → SHIFT with counter=0.
- SHIFT: lasts exactly DECIM cycles, then → CAPTURE.
- CAPTURE: lasts 1 cycle with lfsr_en=0. Actions: rnd_data ← lfsr_data; prev ← lfsr_data; prev_valid ← 1.
  - Health test: if prev_valid=1 and lfsr_data==prev, rep_cnt increments; otherwise rep_cnt ← 1.
  - If the new rep_cnt equals REP_LIMIT → FAULT, and the word is never presented. Otherwise → VALID.
- VALID:
  - rnd_valid=1, and rnd_data is held stable.
  - rnd_valid & rnd_ready → SHIFT with counter=0.
  - The LFSR does not advance while waiting.
- stop=1 in SEED/WARMUP/SHIFT/CAPTURE/VALID → IDLE on the next edge.
  - This takes priority over all other transitions.
  - Any pending word is discarded: rnd_valid drops without a handshake.
- start while busy is ignored.
- FAULT:
  - Terminal state. error=1, busy=0, lfsr_en=0, rnd_valid=0.
  - start and stop are ignored; only rst exits.
- Reset values: state=IDLE, all outputs 0, rnd_data=0, seed register=0, rep_cnt=0, prev_valid=0.
- rst mid-session is immediate: all outputs are 0 the cycle after the rst edge.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
  - Cycle 1: SEED.
  - Cycles 2..1+WARMUP: WARMUP.
  - Cycles 2+WARMUP..1+WARMUP+DECIM: SHIFT.
  - Cycle 2+WARMUP+DECIM: CAPTURE.
  - rnd_valid first goes high in cycle 3+WARMUP+DECIM.
- Handshake in cycle k → next rnd_valid in cycle k+DECIM+2.
  - Minimum word period: DECIM+2 cycles, with rnd_ready tied high.
- CAPTURE samples lfsr_data one cycle after the last lfsr_en, so the word reflects exactly DECIM shifts since the previous capture.
- Fault: error rises the cycle after the offending CAPTURE.

## Test plan
- WARMUP=4, DECIM=10, seed_cfg=0x2A5, 1-cycle start pulse:
  - lfsr_seed_we=1 in cycle 1 only, with lfsr_seed=0x2A5.
  - lfsr_en=1 in cycles 2–15; rnd_valid rises in cycle 17.
- rnd_ready tied high for 5 words: rnd_valid pulses every 12 cycles; lfsr_en count between captures is exactly 10.
- Backpressure, rnd_ready=0 for 7 cycles after valid:
  - rnd_data is stable and lfsr_en=0 throughout.
  - Handshake in cycle k → next valid in cycle k+12.
- Model LFSR returns constant 0x155, REP_LIMIT=3:
  - Words 1 and 2 are presented; the 3rd CAPTURE → error=1 the next cycle, with no rnd_valid.
  - start and stop are then ignored; rst clears error to 0.
- stop asserted during SHIFT, and separately during VALID:
  - Next cycle shows IDLE, busy=0, rnd_valid=0, lfsr_en=0.
  - A new start reseeds, with lfsr_seed_we in cycle 1.
- start=stop=1 in IDLE: stays IDLE. rst during WARMUP: all outputs 0 on the next cycle.
